dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/cache_pkg.sv | 16 +
 rtl/dcache_array.sv | 42 ++++
 rtl/dcache_ctrl.sv | 155 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants for the direct-mapped data cache: controller state encoding
// and address-field widths at the default geometry.
package cache_pkg;

    localparam int BYTE_OFF_W = 2;
    localparam int DEF_SETS = 16;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_IDX_W = $clog2(DEF_SETS);
    localparam int DEF_WORD_W = $clog2(DEF_LINE_WORDS);
    localparam int DEF_TAG_W = 32 - DEF_IDX_W - DEF_WORD_W - BYTE_OFF_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;

endpackage

// File: rtl/dcache_array.sv
// Data and tag storage for the data cache: synchronous byte-enabled write,
// asynchronous read of the CPU word, the write-back word and the line tag.
module dcache_array #(
    parameter int SETS = 16,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W = 4,
    parameter int WORD_W = 2,
    parameter int TAG_W = 24
) (
    input  logic              clk,
    input  logic              data_we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [3:0]        wr_be,
    input  logic [31:0]       wr_data,
    input  logic              tag_we,
    input  logic [TAG_W-1:0]  tag_wdata,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [WORD_W-1:0] cpu_word,
    input  logic [WORD_W-1:0] wb_word,
    output logic [31:0]       cpu_rdata,
    output logic [31:0]       wb_rdata,
    output logic [TAG_W-1:0]  rd_tag
);

    logic [31:0]      data_mem [SETS*LINE_WORDS];
    logic [TAG_W-1:0] tag_mem  [SETS];

    always_ff @(posedge clk) begin
        if (data_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) data_mem[{wr_idx, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        if (tag_we) tag_mem[wr_idx] <= tag_wdata;
    end

    assign cpu_rdata = data_mem[{rd_idx, cpu_word}];
    assign wb_rdata  = data_mem[{rd_idx, wb_word}];
    assign rd_tag    = tag_mem[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with a
// zero-latency hit path and a beat-serial write-back/fill memory interface.
module dcache_ctrl
    import cache_pkg::*;
#(
    parameter int SETS = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        CpuRst_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int TAG_W  = 32 - IDX_W - WORD_W - BYTE_OFF_W;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);
    localparam logic [WORD_W-1:0] BEAT0 = '0;

    logic [1:0]        state;
    logic [WORD_W-1:0] beat;
    logic [SETS-1:0]   valid;
    logic [SETS-1:0]   dirty;
    logic [IDX_W-1:0]  m_idx;
    logic [TAG_W-1:0]  m_tag;

    logic [TAG_W-1:0]  a_tag;
    logic [IDX_W-1:0]  a_idx;
    logic [WORD_W-1:0] a_word;
    logic [IDX_W-1:0]  arr_idx;
    logic [WORD_W-1:0] next_beat;
    logic [31:0]       cpu_rdata;
    logic [31:0]       wb_rdata;
    logic [TAG_W-1:0]  rd_tag;
    logic              req, idle, hit, wb_ack, fill_ack, last;
    logic              unused_ok;

    assign a_tag  = addr[31 -: TAG_W];
    assign a_idx  = addr[BYTE_OFF_W+WORD_W +: IDX_W];
    assign a_word = addr[BYTE_OFF_W +: WORD_W];
    assign unused_ok = ^addr[BYTE_OFF_W-1:0];

    assign req       = rd_req | wr_req;
    assign idle      = (state == ST_IDLE);
    // Outside IDLE the array is addressed by the captured miss line, not the live request
    assign arr_idx   = idle ? a_idx : m_idx;
    assign hit       = req & valid[a_idx] & (rd_tag == a_tag) & idle;
    assign miss      = req & ~hit;
    assign rd_data   = (hit & ~wr_req) ? cpu_rdata : 32'd0;
    assign wb_ack    = (state == ST_WB) & mem_req & mem_ack;
    assign fill_ack  = (state == ST_FILL) & mem_req & mem_ack;
    assign last      = (beat == LAST_BEAT);
    assign next_beat = beat + 1'b1;

    dcache_array #(
        .SETS(SETS), .LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W), .WORD_W(WORD_W), .TAG_W(TAG_W)
    ) u_array (
        .clk       (clk),
        .data_we   ((hit & wr_req) | fill_ack),
        .wr_idx    (arr_idx),
        .wr_word   (fill_ack ? beat : a_word),
        .wr_be     (fill_ack ? 4'hF : wr_be),
        .wr_data   (fill_ack ? mem_rdata : wr_data),
        .tag_we    (fill_ack & last),
        .tag_wdata (m_tag),
        .rd_idx    (arr_idx),
        .cpu_word  (a_word),
        .wb_word   (idle ? BEAT0 : next_beat),
        .cpu_rdata (cpu_rdata),
        .wb_rdata  (wb_rdata),
        .rd_tag    (rd_tag)
    );

    always_ff @(posedge clk) begin
        if (idle && miss) begin
            m_idx <= a_idx;
            m_tag <= a_tag;
        end
    end

    always_ff @(posedge clk or negedge CpuRst_n) begin
        if (!CpuRst_n) begin
            state     <= ST_IDLE;
            beat      <= '0;
            valid     <= '0;
            dirty     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss) begin
                        beat    <= '0;
                        mem_req <= 1'b1;
                        if (valid[a_idx] && dirty[a_idx]) begin
                            state     <= ST_WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= {rd_tag, a_idx, BEAT0, 2'b00};
                            mem_wdata <= wb_rdata;
                        end else begin
                            state     <= ST_FILL;
                            mem_we    <= 1'b0;
                            mem_addr  <= {a_tag, a_idx, BEAT0, 2'b00};
                            mem_wdata <= 32'd0;
                        end
                    end else if (hit && wr_req) begin
                        dirty[a_idx] <= 1'b1;
                    end
                end
                ST_WB: begin
                    if (wb_ack) begin
                        beat <= next_beat;
                        if (last) begin
                            state     <= ST_FILL;
                            mem_we    <= 1'b0;
                            mem_addr  <= {m_tag, m_idx, BEAT0, 2'b00};
                            mem_wdata <= 32'd0;
                        end else begin
                            mem_addr  <= {rd_tag, m_idx, next_beat, 2'b00};
                            mem_wdata <= wb_rdata;
                        end
                    end
                end
                ST_FILL: begin
                    if (fill_ack) begin
                        beat     <= next_beat;
                        mem_addr <= {m_tag, m_idx, next_beat, 2'b00};
                        if (last) begin
                            state        <= ST_IDLE;
                            mem_req      <= 1'b0;
                            valid[m_idx] <= 1'b1;
                            dirty[m_idx] <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a line-level cache model predicts memory
// beats and load data; a negedge monitor/memory responder compares them.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        CpuRst_n = 1'b0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wr_data = 32'd0;
    logic [3:0]  wr_be = 4'd0;
    logic [31:0] rd_data;
    logic        miss;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk(clk), .CpuRst_n(CpuRst_n), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_data(rd_data), .miss(miss),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } beat_t;
    typedef struct packed { logic is_wr; logic [31:0] data; } resp_t;

    int n_cmp = 0;
    int n_bad = 0;

    beat_t exp_beats[$];
    resp_t exp_resp[$];

    // Reference model: line-level view of the cache plus the memory it should see
    logic        m_valid [16];
    logic        m_dirty [16];
    logic [23:0] m_tag   [16];
    logic [31:0] m_data  [16][4];
    logic [31:0] dram_mdl [logic [31:0]];
    logic [31:0] phys     [logic [31:0]];

    int   ack_delay = 0;
    int   acks_seen = 0;
    int   fill_beats = 0;
    logic chk_hit_next = 1'b0;
    logic busy = 1'b0;
    int   wait_left = 0;
    logic [31:0] l_addr, l_wdata;
    logic        l_we;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h9E37, a[15:0]};
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return dram_mdl.exists(a) ? dram_mdl[a] : init_word(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic abort_run(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at %0t", nm, $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    task automatic mdl_reset();
        for (int s = 0; s < 16; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
    endtask

    task automatic mdl_prepare(input logic [31:0] a, output logic h);
        int s;
        logic [23:0] t;
        logic [31:0] ba;
        s = int'(a[7:4]);
        t = a[31:8];
        h = m_valid[s] && (m_tag[s] == t);
        if (!h) begin
            if (m_valid[s] && m_dirty[s]) begin
                for (int w = 0; w < 4; w++) begin
                    ba = {m_tag[s], a[7:4], 2'(w), 2'b00};
                    exp_beats.push_back('{1'b1, ba, m_data[s][w]});
                    dram_mdl[ba] = m_data[s][w];
                end
            end
            for (int w = 0; w < 4; w++) begin
                ba = {t, a[7:4], 2'(w), 2'b00};
                exp_beats.push_back('{1'b0, ba, 32'd0});
                m_data[s][w] = mdl_rd(ba);
            end
            m_valid[s] = 1'b1;
            m_dirty[s] = 1'b0;
            m_tag[s]   = t;
        end
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic h;
        int s, wd, cyc;
        resp_t r;
        mdl_prepare(a, h);
        s  = int'(a[7:4]);
        wd = int'(a[3:2]);
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_data[s][wd][8*b +: 8] = d[8*b +: 8];
            m_dirty[s] = 1'b1;
            r = '{1'b1, 32'd0};
        end else begin
            r = '{1'b0, m_data[s][wd]};
        end
        exp_resp.push_back(r);
        @(posedge clk); #1;
        wr_req  = w;
        rd_req  = w ? 1'($urandom_range(0, 1)) : 1'b1;
        addr    = a;
        wr_data = d;
        wr_be   = be;
        @(negedge clk);
        chk("miss_first_cycle", miss, !h);
        cyc = 0;
        while (miss && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (miss) abort_run("miss_wait");
        @(posedge clk); #1;
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    task automatic wait_acks(input int target);
        int cyc = 0;
        while (acks_seen < target && cyc < 400) begin
            @(posedge clk);
            cyc++;
        end
        if (acks_seen < target) abort_run("ack_wait");
    endtask

    // Monitor and memory responder share the negedge so beats and responses are seen in order
    always @(negedge clk) begin
        resp_t r;
        beat_t b;
        if (chk_hit_next) begin
            chk_hit_next = 1'b0;
            if ((rd_req || wr_req) && CpuRst_n) chk("miss_after_fill", miss, 1'b0);
        end
        if ((rd_req || wr_req) && !miss && CpuRst_n) begin
            if (exp_resp.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got rd_data %h expected no response", rd_data);
            end else begin
                r = exp_resp.pop_front();
                chk(r.is_wr ? "store_rd_data" : "load_rd_data", rd_data, r.data);
            end
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        if (!CpuRst_n) begin
            busy = 1'b0;
        end else if (mem_req) begin
            if (!busy) begin
                busy      = 1'b1;
                wait_left = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
                l_addr    = mem_addr;
                l_we      = mem_we;
                l_wdata   = mem_wdata;
            end else begin
                chk("beat_addr_stable", mem_addr, l_addr);
                chk("beat_we_stable", mem_we, l_we);
                chk("beat_wdata_stable", mem_wdata, l_wdata);
            end
            if (wait_left == 0) begin
                busy    = 1'b0;
                mem_ack = 1'b1;
                acks_seen++;
                if (exp_beats.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got addr %h we %b expected none", mem_addr, mem_we);
                end else begin
                    b = exp_beats.pop_front();
                    chk("beat_addr", mem_addr, b.addr);
                    chk("beat_we", mem_we, b.we);
                    if (b.we) chk("beat_wdata", mem_wdata, b.wdata);
                end
                if (mem_we) begin
                    phys[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata = phys.exists(mem_addr) ? phys[mem_addr] : init_word(mem_addr);
                    fill_beats++;
                    if (fill_beats == 4) begin
                        fill_beats   = 0;
                        chk_hit_next = 1'b1;
                    end
                end
            end else begin
                wait_left--;
            end
        end else begin
            if (busy) chk("beat_req_held", mem_req, 1'b1);
            busy    = 1'b0;
            mem_ack = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        logic h;
        logic w;
        logic [31:0] a;
        mdl_reset();
        phys[32'h14]     = 32'h1111_2222;
        dram_mdl[32'h14] = 32'h1111_2222;

        // Reset state, with the combinational outputs still live
        #12;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_miss_noreq", miss, 1'b0);
        chk("rst_rd_data", rd_data, 32'd0);
        rd_req = 1'b1;
        addr   = 32'h10;
        #1;
        chk("rst_miss_req", miss, 1'b1);
        rd_req = 1'b0;
        @(posedge clk); #2;
        CpuRst_n = 1'b1;

        // Cold read, store hit with partial byte enables, then dirty conflict
        access(1'b0, 32'h0000_0010, 32'd0, 4'h0);
        access(1'b1, 32'h0000_0014, 32'hAAAA_BBBB, 4'b0011);
        access(1'b0, 32'h0000_0014, 32'd0, 4'h0);
        access(1'b0, 32'h0000_0110, 32'd0, 4'h0);
        chk("wb_merged_word", phys.exists(32'h14) ? phys[32'h14] : 32'hX, 32'h1111_BBBB);

        // Slow memory
        ack_delay = 3;
        access(1'b0, 32'h0000_0220, 32'd0, 4'h0);
        access(1'b1, 32'h0000_001C, 32'h1234_5678, 4'b1111);

        // Reset pulse while the fill is on its third beat
        ack_delay = 0;
        a = 32'h0000_0330;
        mdl_prepare(a, h);
        @(posedge clk); #1;
        rd_req = 1'b1;
        addr   = a;
        wait_acks(acks_seen + 2);
        #2;
        CpuRst_n = 1'b0;
        #1;
        chk("rst_mid_fill_mem_req", mem_req, 1'b0);
        chk("rst_mid_fill_miss", miss, 1'b1);
        mdl_reset();
        exp_beats.delete();
        exp_resp.delete();
        fill_beats   = 0;
        chk_hit_next = 1'b0;
        rd_req = 1'b0;
        @(posedge clk); #2;
        CpuRst_n = 1'b1;
        access(1'b0, a, 32'd0, 4'h0);

        // Request withdrawn mid-fill: the line must still arrive intact
        ack_delay = -1;
        a = 32'h0000_0444;
        mdl_prepare(a, h);
        @(posedge clk); #1;
        rd_req = 1'b1;
        addr   = a;
        wait_acks(acks_seen + 1);
        #1;
        rd_req = 1'b0;
        for (int i = 0; i < 100 && exp_beats.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("drop_fill_drained", exp_beats.size(), 0);
        access(1'b0, a, 32'd0, 4'h0);

        // Randomised traffic over four tags so conflicts and write-backs are frequent
        for (int i = 0; i < 250; i++) begin
            w = 1'($urandom_range(0, 1));
            a = {22'd0, 10'($urandom_range(0, 1023))} & 32'hFFFF_FFFC;
            access(w, a, $urandom, 4'($urandom_range(1, 15)));
        end

        repeat (10) @(posedge clk);
        chk("beats_drained", exp_beats.size(), 0);
        chk("resps_drained", exp_resp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        abort_run("global_timeout");
    end

endmodule
